// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler that shares one CRC-framed UART transmitter between
// NUM_REQ byte producers. One byte is accepted per grant and handed to the
// transmitter with a start pulse. The arbiter then waits for the rising edge
// of tx_done, or gives up after a watchdog timeout. A fixed idle gap is
// enforced before the next grant.
//
// Ports
//   clk          system clock (10 MHz)
//   rst          asynchronous reset, active low
//   req_valid    per-requester "byte pending"
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   req_ready    one-hot, one-cycle accept strobe
//   tx_start     one-cycle start pulse to the transmitter
//   data_in      latched byte, held stable until the next grant
//   tx_done      transmitter completion (only the rising edge is used)
//   busy         high in every state except IDLE
//   grant_id     index of the last granted requester
//   timeout_err  one-cycle pulse when a frame is abandoned
//   frame_count  frames completed through tx_done (wraps at 16 bits)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int GAP_CLKS     = 1042,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          data_in,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    output logic [15:0]                frame_count
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                tx_done_q;
    logic                done_rise_s, to_hit_s, gap_end_s, any_req_s;
    logic [ID_W-1:0]     pick_s;
    logic [DATA_W-1:0]   sel_data_s;

    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                timeout_err_q, timeout_err_d;
    logic [15:0]         frame_q, frame_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    // First set bit of valid, searching last+1, last+2, ... modulo NUM_REQ.
    // The sum is kept one bit wider so last+k never wraps before the compare.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0]  pick;
        logic             found;
        logic [IDX_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (!found && valid[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign any_req_s   = |req_valid;
    assign pick_s      = rr_pick(req_valid, last_q);
    assign done_rise_s = tx_done & ~tx_done_q;
    assign to_hit_s    = (int'(to_cnt_q) == TIMEOUT_CLKS - 1);
    // GAP always lasts at least one cycle, so GAP_CLKS of 0 or 1 both exit at once.
    assign gap_end_s   = (int'(gap_cnt_q) + 1 >= GAP_CLKS);

    // Byte mux for the winning requester.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = (pick_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req_s ? S_START : S_IDLE;
            S_START: state_d = S_WAIT;
            S_WAIT:  state_d = (done_rise_s || to_hit_s) ? S_GAP : S_WAIT;
            S_GAP:   state_d = gap_end_s ? S_IDLE : S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; every output is registered below.
    always_comb begin
        req_ready_d   = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        data_d        = data_q;
        grant_d       = grant_q;
        last_d        = last_q;
        frame_d       = frame_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    req_ready_d = NUM_REQ'(1) << pick_s;
                    tx_start_d  = 1'b1;
                    data_d      = sel_data_s;
                    grant_d     = pick_s;
                    last_d      = pick_s;
                end else begin
                    req_ready_d = '0;
                end
            end
            S_START: begin
                to_cnt_d = '0;
            end
            S_WAIT: begin
                // A completion edge beats a timeout landing in the same cycle.
                if (done_rise_s) begin
                    frame_d   = frame_q + 16'd1;
                    gap_cnt_d = '0;
                end else if (to_hit_s) begin
                    timeout_err_d = 1'b1;
                    gap_cnt_d     = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (!gap_end_s) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q;
                end
            end
            default: begin
                req_ready_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Output and counter registers; the edge register resets high so a
    // tx_done already asserted at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_done_q     <= 1'b1;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            grant_q       <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            timeout_err_q <= 1'b0;
            frame_q       <= 16'd0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            tx_done_q     <= tx_done;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            timeout_err_q <= timeout_err_d;
            frame_q       <= frame_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign data_in     = data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// frames. Expected grants, data, counts and timing come from a round-robin
// model over an array of pending requesters.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 1042;
    localparam int TO  = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             tx_start;
    logic [W-1:0]     data_in;
    logic             tx_done;
    logic             busy;
    logic [1:0]       grant_id;
    logic             timeout_err;
    logic [15:0]      frame_count;

    int        checks = 0;
    int        passed = 0;
    bit        pend   [N];
    bit        sticky [N];
    logic [7:0] dat   [N];
    int        last_m;
    int        exp_frames;

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_W(W), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .data_in(data_in),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err), .frame_count(frame_count)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend[i];
            req_data[i*W +: W]   = dat[i];
        end
    endtask

    // Round-robin rule: first pending requester after the last grant, cyclically.
    function automatic int exp_pick();
        for (int k = 1; k <= N; k++) begin
            if (pend[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) a = a | pend[i];
        return a;
    endfunction

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_data_in"}, data_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
    endtask

    // Called at the negedge where tx_start is expected high; ends one cycle later.
    task automatic grant_step();
        int g;
        g = exp_pick();
        if (g < 0) begin
            chk("grant_has_pending", 0, 1);
            return;
        end
        chk("tx_start", tx_start, 1);
        chk("req_ready", req_ready, 32'd1 << g);
        chk("data_in", data_in, dat[g]);
        chk("grant_id", grant_id, g);
        chk("busy_at_start", busy, 1);
        last_m  = g;
        pend[g] = sticky[g];
        drive();
        @(negedge clk);
        chk("tx_start_width", tx_start, 0);
        chk("req_ready_width", req_ready, 0);
        chk("busy_in_wait", busy, 1);
    endtask

    // k counts cycles after the completion/timeout cycle; k=1 is the first GAP cycle.
    task automatic gap_phase(input int k0, input int lower_at);
        bit pa, seen;
        pa   = any_pend();
        seen = 1'b0;
        for (int k = k0; (k <= GAP + 8) && !seen; k++) begin
            @(negedge clk);
            if (k == lower_at) tx_done = 1'b0;
            if (k == 2) begin
                chk("frame_count", frame_count, exp_frames);
                chk("timeout_err_quiet", timeout_err, 0);
                chk("busy_in_gap", busy, 1);
            end
            if (pa) begin
                if (tx_start === 1'b1) begin
                    seen = 1'b1;
                    chk("gap_spacing", k, GAP + 2);
                end
            end else if (k == GAP) begin
                chk("busy_gap_last", busy, 1);
            end else if (k == GAP + 1) begin
                chk("busy_back_idle", busy, 0);
                seen = 1'b1;
            end
        end
        if (!seen) chk("gap_exit_seen", 0, 1);
    endtask

    task automatic done_step(input int delay, input int lower_at);
        repeat (delay) @(negedge clk);
        chk("no_early_done", frame_count, exp_frames);
        tx_done    = 1'b1;
        exp_frames = exp_frames + 1;
        gap_phase(1, lower_at);
    endtask

    task automatic idle_request(input int i, input logic [7:0] d);
        pend[i] = 1'b1;
        dat[i]  = d;
        drive();
        @(negedge clk);
    endtask

    initial begin
        int tk;
        bit tseen;
        rst = 1'b0; tx_done = 1'b0; req_valid = '0; req_data = '0;
        last_m = N - 1; exp_frames = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; sticky[i] = 1'b0; dat[i] = 8'h00; end
        repeat (3) @(negedge clk);
        reset_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Simultaneous requests: grants 0,1,2,3.
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; dat[i] = 8'h10 + 8'(i); end
        drive();
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            chk("simul_order", exp_pick(), j);
            grant_step();
            done_step(20 + 10 * j, 3);
        end
        chk("simul_frames", frame_count, 4);

        // Fairness: 0 and 2 held valid continuously.
        sticky[0] = 1'b1; sticky[2] = 1'b1; dat[0] = 8'hC0; dat[2] = 8'hC2;
        pend[0] = 1'b1; pend[2] = 1'b1;
        drive();
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk("fair_order", exp_pick(), (j % 2) * 2);
            grant_step();
            if (j == 3) begin
                for (int i = 0; i < N; i++) begin sticky[i] = 1'b0; pend[i] = 1'b0; end
                drive();
            end
            done_step(30, 2);
        end

        // Single grant.
        idle_request(0, 8'h3F);
        grant_step();
        done_step(50, 3);

        // Timeout with tx_done stuck low; requester 2 waits for the gap.
        idle_request(1, 8'hA5);
        grant_step();
        tseen = 1'b0;
        tk = 0;
        for (int k = 2; (k <= TO + 5) && !tseen; k++) begin
            @(negedge clk);
            if (k == 100) begin pend[2] = 1'b1; dat[2] = 8'h77; drive(); end
            if (timeout_err === 1'b1) begin tseen = 1'b1; tk = k; end
        end
        chk("timeout_latency", tk, TO + 1);
        chk("timeout_frames", frame_count, exp_frames);
        gap_phase(2, 0);
        grant_step();
        done_step(25, 2);

        // Stale done: tx_done stays high across the next grant.
        idle_request(3, 8'h5A);
        grant_step();
        pend[0] = 1'b1; dat[0] = 8'h81; drive();
        done_step(40, 0);
        grant_step();
        repeat (200) @(negedge clk);
        chk("stale_no_done", frame_count, exp_frames);
        chk("stale_busy", busy, 1);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        done_step(2, 2);

        // Reset in WAIT_DONE, released with requesters 1 and 3 pending.
        idle_request(0, 8'hE1);
        grant_step();
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        reset_outputs_zero("midreset");
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        pend[1] = 1'b1; dat[1] = 8'h31;
        pend[3] = 1'b1; dat[3] = 8'h33;
        tx_done = 1'b1;
        drive();
        last_m = N - 1; exp_frames = 0;
        @(negedge clk);
        chk("midreset_hold_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_first", grant_id, 1);
        grant_step();
        repeat (50) @(negedge clk);
        chk("release_no_edge", frame_count, 0);
        tx_done = 1'b0;
        repeat (2) @(negedge clk);
        done_step(3, 3);
        grant_step();
        done_step(10, 2);

        // Randomized frames with arrivals and withdrawals during WAIT_DONE.
        for (int f = 0; f < 12; f++) begin
            if (tx_start !== 1'b1) begin
                if (!any_pend()) begin
                    tk = $urandom_range(0, N - 1);
                    pend[tk] = 1'b1;
                    dat[tk] = 8'($urandom_range(0, 255));
                end
                drive();
                @(negedge clk);
            end
            grant_step();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom_range(0, 255));
                end else if (pend[i] && ($urandom_range(0, 4) == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            drive();
            done_step($urandom_range(5, 200), $urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single CRC-framed UART transmitter (`uart_top` TX path: 8 data bits + 4-bit CRC per frame) between up to `NUM_REQ` byte producers. It accepts one byte per grant, drives `tx_start`/`data_in` into `uart_top`, and waits for the frame to finish. Completion is the rising edge of `tx_done`, or a watchdog timeout. An idle gap is enforced between frames. Sits between on-chip byte sources and `uart_top`; the receive path is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; matches `uart_top` `data_in`.
- `GAP_CLKS`, 1042: idle cycles between frame completion and the next grant. One bit period at 10 MHz / 9600 baud. 0 is legal.
- `TIMEOUT_CLKS`, 20000: cycles in WAIT_DONE before the frame is abandoned. Must exceed 14 × 1042.
- `clk`  in  1  system clock, 10 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_data`  in  NUM_REQ*DATA_W  requester i byte is at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept strobe.
- `tx_start`  out  1  one-cycle start pulse to `uart_top`.
- `data_in`  out  DATA_W  latched byte to `uart_top`; held stable until the next grant.
- `tx_done`  in  1  `uart_top` completion; only the rising edge is used.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  clog2(NUM_REQ)  index of the last granted requester.
- `timeout_err`  out  1  one-cycle pulse when a frame times out.
- `frame_count`  out  16  frames completed via `tx_done`; wraps from 0xFFFF to 0.

## Operation
- Reset (`rst`=0, asynchronous):
  - State = IDLE.
  - All outputs = 0.
  - Internal `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - Gap and timeout counters = 0.
  - `tx_done` edge register = 1, so a `tx_done` already high at reset release is not an edge.
- Edge detect: `done_rise` = `tx_done` & ~`tx_done_q`, with `tx_done_q` registered every cycle in all states.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If `req_valid` is nonzero, select g = first set bit searching `last_grant`+1, +2, … modulo NUM_REQ.
  - At the next edge, all of the following happen together:
    - `req_ready[g]` = 1.
    - `tx_start` = 1.
    - `data_in` = `req_data[g]`.
    - `grant_id` = g.
    - `last_grant` = g.
    - State → START.
  - If `req_valid` is zero, remain in IDLE.
- START, one cycle:
  - `req_ready` and `tx_start` return to 0 at the next edge.
  - Timeout counter is cleared.
  - State → WAIT_DONE.
- WAIT_DONE:
  - Timeout counter increments every cycle.
  - On `done_rise`: `frame_count` += 1, state → GAP.
  - Else, when the counter reaches TIMEOUT_CLKS-1: `timeout_err` pulses for one cycle, `frame_count` is unchanged, state → GAP.
  - If `done_rise` and timeout occur in the same cycle, `done_rise` wins and no `timeout_err` is raised.
- GAP:
  - Counts GAP_CLKS cycles, then state → IDLE.
  - If GAP_CLKS = 0, state → IDLE on the next edge.
- `req_valid` is ignored outside IDLE. Pending requests wait; no request is dropped.
- Requester rule:
  - Hold `req_valid`/`req_data` stable until `req_ready` is seen.
  - Dropping `req_valid` before the grant withdraws the request, with no side effects.
- Reset mid-frame aborts arbitration instantly. `uart_top` shares `rst` and aborts too. No pulse is replayed after release.

## Timing
- Latency from `req_valid` sampled in IDLE to `tx_start`/`req_ready` high: 1 cycle. Both are registered and high in the same cycle.
- `tx_start` width: exactly 1 cycle per grant.
- Back-to-back spacing: next `tx_start` comes ≥ GAP_CLKS + 2 cycles after the `done_rise` cycle.
- `timeout_err` rises TIMEOUT_CLKS + 1 cycles after the `tx_start` cycle.
- `busy` is high from the `tx_start` cycle until the cycle in which the state returns to IDLE.

## Test plan
- Single grant:
  - Stimulus: `req_valid`=4'b0001, data 0x3F.
  - Required: `req_ready`=0001 and `tx_start`=1 for one cycle, `data_in`=0x3F, `grant_id`=0, one CRC frame on `tx` (CRC 4'b0101), then `frame_count`=1.
- Simultaneous requests:
  - Stimulus: all four valid, data 0x10/0x11/0x12/0x13.
  - Required: grants in order 0,1,2,3; each `tx_start` ≥ 1044 cycles after the previous `done_rise`; `frame_count`=4.
- Fairness:
  - Stimulus: requesters 0 and 2 held valid continuously.
  - Required: grant sequence 0,2,0,2; requesters 1 and 3 are never acknowledged.
- Timeout:
  - Stimulus: stub `tx_done` tied low.
  - Required: `timeout_err` pulses once, 20001 cycles after `tx_start`; `frame_count` stays 0; the next pending request is granted after the gap.
- Stale done:
  - Stimulus: `tx_done` held high across a new grant.
  - Required: no early completion; completion occurs only on a fresh low→high edge.
- Reset mid-frame:
  - Stimulus: `rst`=0 in WAIT_DONE, then released with requesters 1 and 3 valid.
  - Required: all outputs are 0 immediately while `rst` is low; after release, requester 1 is granted first.
